alu_microstep_sequencer: RTL
============================

# alu_microstep_sequencer

Parametrised control sequencer for the CPU datapath. It replaces hand-written per-instruction state lists with one FSM that drives every datapath strobe: fetch (T0–T2), register-to-register ALU execute (T3–T5), and the extra HI/LO write-back step (T6) for multiply/divide. It sits between the instruction register and the `CPU_Datapath` control inputs, with a start/busy/done handshake towards the top-level run control and a memory-ready wait in T1.

## Interface
Parameters:
- `NUM_REGS`, 16: general registers; width of the one-hot `Rin`/`Rout` buses.
- `REG_ADDR_W`, 4: register field width in IR; `NUM_REGS <= 2**REG_ADDR_W`.
- `ALU_SEL_W`, 5: opcode / ALU selection width.
- `IR_W`, 32: instruction width.
- `R0_WRITABLE`, 1: when 0, `Rin[0]` is never asserted.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `start` in 1: begin one instruction. Sampled in IDLE only.
- `mem_ready` in 1: memory data valid on `Mdatain`. Ends the T1 wait.
- `ir` in IR_W: IR register contents. Fields: opcode `[IR_W-1 -: ALU_SEL_W]`, then ra, rb, rc, each REG_ADDR_W wide, MSB-first.
- `busy` out 1: high in T0–T6.
- `done` out 1: one-cycle pulse after the final step.
- `illegal` out 1: one-cycle pulse when the opcode is unsupported.
- `Rin` out NUM_REGS: one-hot register load enables.
- `Rout` out NUM_REGS: one-hot register bus drives.
- `PCout`, `MARin`, `IncPC`, `Zin`, `ZLOout`, `ZHIout`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `LOin`, `HIin` out 1 each: datapath strobes.
- `ALUSelection` out ALU_SEL_W: ALU operation select.

## Operation
- Reset value is 0 on every output; the state resets to IDLE.
- Outputs are Moore outputs decoded from the state. The exceptions are `PCin` and the opcode-dependent fields, which are qualified as stated below.
- States and the strobes asserted in each:
  - IDLE: nothing asserted. `start` → T0.
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`. → T1.
  - T1: `ZLOout`, `Read`, `MDRin`; `PCin` only while `mem_ready`=1. Stays in T1 while `mem_ready`=0; → T2 when `mem_ready`=1.
  - T2: `MDRout`, `IRin`. → T3.
  - T3: `Rout[rb]`, `Yin`. If opcode is illegal → IDLE and pulse `illegal`. Otherwise → T4.
  - T4: `Rout[rc]`, `Zin`, `ALUSelection`=opcode. → T5.
  - T5: `ZLOout`. For an ALU-class opcode also assert `Rin[ra]`, then → IDLE with `done`. For MUL/DIV also assert `LOin`, then → T6.
  - T6: `ZHIout`, `HIin`. → IDLE with `done`.
- Opcode classes are defined in the package:
  - ALU: `5'h00`–`5'h0D`.
  - MUL: `5'h0E`.
  - DIV: `5'h0F`.
  - Everything else is illegal.
- `ALUSelection` is 0 outside T4.
- `Rin`/`Rout` are zero when the indexed field is ≥ `NUM_REGS`. That case counts as illegal and is checked in T3.
- `ra`=0 with `R0_WRITABLE`=0: the sequence completes with `done`, but no `Rin` bit is set.
- `start` while busy is ignored; no queueing.
- `start` held high: a new instruction starts on the cycle after `done`.
- `clr` low at any point returns to IDLE asynchronously and forces all outputs to 0 the same instant. No `done` or `illegal` is produced for the aborted instruction.

## Timing
- `start` sampled high in IDLE at edge N → T0 during cycle N+1.
- ALU op with `mem_ready` high: busy for 6 cycles (T0–T5); `done` in cycle N+7.
- MUL/DIV op: busy for 7 cycles; `done` in cycle N+8.
- Each cycle with `mem_ready` low in T1 adds one cycle of latency.
- Illegal op: busy for 4 cycles; `illegal` pulses in cycle N+5; `done` stays low.
- `done` and `illegal` are registered and mutually exclusive.
- At most one bit of `Rout` is set at any time.
- `ir` must be stable from T3 through the final step. The block latches nothing from `ir`.

## Structure
- Package `seq_pkg` holds:
  - the state enum (IDLE, T0…T6) with 3-bit encoding;
  - the opcode class constants `OPC_MUL` and `OPC_DIV`;
  - the `OPC_ALU_MAX` constant (5'h0D);
  - field-offset localparams.
- Sub-module `seq_field_decode`: extracts opcode/ra/rb/rc from `ir` and produces the one-hot vectors plus the legality flag.
- The FSM, the output decode and the done/illegal registers live in the top module.

## Test plan
- Reset: hold `clr`=0 with `start`=1 → all outputs 0. Release → still IDLE until `start` is sampled.
- ALU op: `ir`=0x28918000 (opcode 5, ra=1, rb=2, rc=3), `mem_ready`=1. Expect:
  - `Rout`=0x0004 with `Yin` in T3;
  - `Rout`=0x0008, `ALUSelection`=5, `Zin` in T4;
  - `Rin`=0x0002 with `ZLOout` in T5;
  - `done` 7 cycles after `start`.
- Memory wait: `mem_ready` low for 3 cycles in T1 → T1 lasts 4 cycles, `PCin` is high only in the final one, and `done` arrives 3 cycles later than in the ALU-op case.
- MUL: opcode 0x0E, ra=4 → `LOin`+`ZLOout` in T5, `HIin`+`ZHIout` in T6, no `Rin`, `done` at N+8.
- Illegal and R0 cases:
  - opcode 0x1F → `illegal` pulses after T3, and no `Rin`/`Zin` is asserted after T3;
  - `R0_WRITABLE`=0, ra=0 → `done` with `Rin` always 0.
- Abort: drop `clr` during T4 → outputs go to 0 immediately, no `done` follows, and a fresh `start` runs normally.

Source files
------------

// File: rtl/alu_microstep_sequencer_pkg.sv
// Shared types and constants for the microstep sequencer: state encoding, opcode classes and
// instruction field placement.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6
  } seq_state_e;

  localparam int unsigned OPC_ALU_MAX = 32'h0D;
  localparam int unsigned OPC_MUL     = 32'h0E;
  localparam int unsigned OPC_DIV     = 32'h0F;

  // Register fields follow the opcode MSB-first in this order.
  localparam int unsigned FLD_RA = 0;
  localparam int unsigned FLD_RB = 1;
  localparam int unsigned FLD_RC = 2;

  function automatic int unsigned field_msb(int unsigned ir_w, int unsigned sel_w,
                                            int unsigned addr_w, int unsigned fld);
    return ir_w - 1 - sel_w - fld * addr_w;
  endfunction

endpackage

// File: rtl/alu_microstep_sequencer_field_decode.sv
// Splits the instruction word into opcode and register fields, one-hot encodes the registers
// and classifies the opcode.
module seq_field_decode
  import seq_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned ALU_SEL_W  = 5,
  parameter int unsigned IR_W       = 32
) (
  input  logic [IR_W-1:0]      i_ir,
  output logic [ALU_SEL_W-1:0] o_opcode,
  output logic [NUM_REGS-1:0]  o_ra_oh,
  output logic [NUM_REGS-1:0]  o_rb_oh,
  output logic [NUM_REGS-1:0]  o_rc_oh,
  output logic                 o_is_muldiv,
  output logic                 o_legal
);

  localparam int unsigned RaMsb = field_msb(IR_W, ALU_SEL_W, REG_ADDR_W, FLD_RA);
  localparam int unsigned RbMsb = field_msb(IR_W, ALU_SEL_W, REG_ADDR_W, FLD_RB);
  localparam int unsigned RcMsb = field_msb(IR_W, ALU_SEL_W, REG_ADDR_W, FLD_RC);

  logic [REG_ADDR_W-1:0] w_ra;
  logic [REG_ADDR_W-1:0] w_rb;
  logic [REG_ADDR_W-1:0] w_rc;
  logic                  w_is_alu;
  logic                  w_fields_ok;

  assign o_opcode = i_ir[IR_W-1 -: ALU_SEL_W];
  assign w_ra     = i_ir[RaMsb -: REG_ADDR_W];
  assign w_rb     = i_ir[RbMsb -: REG_ADDR_W];
  assign w_rc     = i_ir[RcMsb -: REG_ADDR_W];

  assign w_is_alu    = 32'(o_opcode) <= OPC_ALU_MAX;
  assign o_is_muldiv = (32'(o_opcode) == OPC_MUL) || (32'(o_opcode) == OPC_DIV);

  // Out-of-range register indices yield an all-zero vector and make the instruction illegal.
  assign w_fields_ok = (32'(w_ra) < NUM_REGS) && (32'(w_rb) < NUM_REGS) &&
                       (32'(w_rc) < NUM_REGS);
  assign o_legal     = (w_is_alu || o_is_muldiv) && w_fields_ok;

  always_comb begin
    o_ra_oh = '0;
    o_rb_oh = '0;
    o_rc_oh = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      o_ra_oh[i] = (32'(w_ra) == i);
      o_rb_oh[i] = (32'(w_rb) == i);
      o_rc_oh[i] = (32'(w_rc) == i);
    end
  end

  if (RcMsb >= REG_ADDR_W) begin : g_spare
    logic w_unused_ir_lsbs;
    assign w_unused_ir_lsbs = ^i_ir[RcMsb-REG_ADDR_W:0];
  end

endmodule

// File: rtl/alu_microstep_sequencer.sv
// Microstep control FSM for fetch, register-register ALU execute and the HI/LO write-back step
// of multiply/divide, with start/busy/done handshake and a memory-ready wait in T1.
module alu_microstep_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned ALU_SEL_W   = 5,
  parameter int unsigned IR_W        = 32,
  parameter int unsigned R0_WRITABLE = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 mem_ready,
  input  logic [IR_W-1:0]      ir,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic [NUM_REGS-1:0]  Rin,
  output logic [NUM_REGS-1:0]  Rout,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Zin,
  output logic                 ZLOout,
  output logic                 ZHIout,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 LOin,
  output logic                 HIin,
  output logic [ALU_SEL_W-1:0] ALUSelection
);

  localparam logic [NUM_REGS-1:0] RinMask = (R0_WRITABLE != 0) ? {NUM_REGS{1'b1}} :
                                            {{(NUM_REGS-1){1'b1}}, 1'b0};

  seq_state_e            r_state;
  logic                  r_done;
  logic                  r_illegal;
  logic [ALU_SEL_W-1:0]  w_opcode;
  logic [NUM_REGS-1:0]   w_ra_oh;
  logic [NUM_REGS-1:0]   w_rb_oh;
  logic [NUM_REGS-1:0]   w_rc_oh;
  logic                  w_is_muldiv;
  logic                  w_legal;

  seq_field_decode #(
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W),
    .ALU_SEL_W (ALU_SEL_W),
    .IR_W      (IR_W)
  ) u_field_decode (
    .i_ir       (ir),
    .o_opcode   (w_opcode),
    .o_ra_oh    (w_ra_oh),
    .o_rb_oh    (w_rb_oh),
    .o_rc_oh    (w_rc_oh),
    .o_is_muldiv(w_is_muldiv),
    .o_legal    (w_legal)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= StIdle;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        StIdle: if (start) r_state <= StT0;
        StT0:   r_state <= StT1;
        StT1:   if (mem_ready) r_state <= StT2;
        StT2:   r_state <= StT3;
        StT3: begin
          if (w_legal) begin
            r_state <= StT4;
          end else begin
            r_state   <= StIdle;
            r_illegal <= 1'b1;
          end
        end
        StT4:   r_state <= StT5;
        StT5: begin
          if (w_is_muldiv) begin
            r_state <= StT6;
          end else begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        StT6: begin
          r_state <= StIdle;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign done    = r_done;
  assign illegal = r_illegal;

  // Strobes decode straight from the state so an asynchronous clear blanks them at once.
  always_comb begin
    busy         = (r_state != StIdle);
    Rin          = '0;
    Rout         = '0;
    PCout        = 1'b0;
    MARin        = 1'b0;
    IncPC        = 1'b0;
    Zin          = 1'b0;
    ZLOout       = 1'b0;
    ZHIout       = 1'b0;
    PCin         = 1'b0;
    Read         = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    LOin         = 1'b0;
    HIin         = 1'b0;
    ALUSelection = '0;
    unique case (r_state)
      StIdle: ;
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        ZLOout = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
        PCin   = mem_ready;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        Rout = w_rb_oh;
        Yin  = 1'b1;
      end
      StT4: begin
        Rout         = w_rc_oh;
        Zin          = 1'b1;
        ALUSelection = w_opcode;
      end
      StT5: begin
        ZLOout = 1'b1;
        if (w_is_muldiv) begin
          LOin = 1'b1;
        end else if (w_legal) begin
          Rin = w_ra_oh & RinMask;
        end
      end
      StT6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
    endcase
  end

endmodule
